// File: rtl/pnode_dispatch.sv
// pnode_dispatch: steers whole packets from the muxed Ethernet stream to one of NCOUNT processing nodes.
// Latency: 1 cycle from input accept to pnode_valid, through a single registered output stage.
// Backpressure: st_ready falls when the output register is held by its node, or no node can take a new packet.
//
// Ports:
//   clock, sclr          : clk312 domain clock, synchronous active-high reset
//   st_*                 : input stream (data/channel/empty/sop/eop) with valid/ready handshake
//   node_enable/freeze   : per-node eligibility (enabled and not frozen), already synchronised
//   pnode_data/valid/rdy : per-node output; all slices carry the same word, valid is one-hot
//   drop_count           : saturating count of dropped or truncated packets
//   busy                 : high whenever the packet state machine is not idle
module pnode_dispatch #(
    parameter int DATA_W  = 128,
    parameter int CH_W    = 8,
    parameter int NCOUNT  = 8,
    parameter int MODE    = 0,
    parameter int EMPTY_W = 4,
    parameter int PW      = DATA_W + CH_W + EMPTY_W + 2
) (
    input  logic                 clock,
    input  logic                 sclr,
    input  logic [DATA_W-1:0]    st_data,
    input  logic [CH_W-1:0]      st_channel,
    input  logic [EMPTY_W-1:0]   st_empty,
    input  logic                 st_sop,
    input  logic                 st_eop,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [NCOUNT-1:0]    node_enable,
    input  logic [NCOUNT-1:0]    node_freeze,
    output logic [NCOUNT*PW-1:0] pnode_data,
    output logic [NCOUNT-1:0]    pnode_valid,
    input  logic [NCOUNT-1:0]    pnode_ready,
    output logic [31:0]          drop_count,
    output logic                 busy
);
    localparam int IDX_W = $clog2(NCOUNT);
    // Channel widened so the modulo divisor never truncates, even for narrow channels.
    localparam logic [CH_W+5:0] NCOUNT_EXT = (CH_W + 6)'(NCOUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic              out_full_q, out_full_d;
    logic [PW-1:0]     out_word_q, out_word_d;
    logic [NCOUNT-1:0] out_tgt_q, out_tgt_d;
    logic [31:0]       drop_count_q, drop_count_d;

    logic [NCOUNT-1:0] elig;
    logic              out_xfer;
    logic              can_load;
    logic              rr_found;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W-1:0]  st_idx;
    logic [IDX_W-1:0]  tgt_idx;
    logic              tgt_ok;
    logic              accept;
    logic              load;
    logic [IDX_W-1:0]  load_idx;
    logic              drop_inc;
    logic              new_pkt;

    // (a + b) mod NCOUNT for b in [0, NCOUNT); works for non-power-of-two node counts.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NCOUNT) begin
            s = s - NCOUNT;
        end
        return IDX_W'(s);
    endfunction

    assign elig     = node_enable & ~node_freeze;
    assign out_xfer = out_full_q & (|(out_tgt_q & pnode_ready));
    // Loading while the held word leaves keeps one word per cycle through the stage.
    assign can_load = ~out_full_q | out_xfer;
    assign accept   = st_valid & st_ready;

    // Round-robin search: scan offsets from high to low so the lowest offset
    // from rr_ptr is the last (winning) assignment.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = NCOUNT - 1; k >= 0; k--) begin
            if (elig[wrap_add(rr_ptr_q, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    assign st_idx  = IDX_W'({6'd0, st_channel} % NCOUNT_EXT);
    assign tgt_idx = (MODE == 0) ? rr_idx : st_idx;
    assign tgt_ok  = (MODE == 0) ? rr_found : elig[st_idx];

    // ---------------------------------------------------------------
    // State register and all datapath flops
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            out_full_q   <= 1'b0;
            out_word_q   <= '0;
            out_tgt_q    <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            out_full_q   <= out_full_d;
            out_word_q   <= out_word_d;
            out_tgt_q    <= out_tgt_d;
            drop_count_q <= drop_count_d;
        end
    end

    // ---------------------------------------------------------------
    // Output / control decode: st_ready and the per-cycle strobes
    // ---------------------------------------------------------------
    always_comb begin
        st_ready = 1'b0;
        load     = 1'b0;
        load_idx = sel_q;
        drop_inc = 1'b0;
        new_pkt  = 1'b0;
        if (!sclr) begin
            case (state_q)
                S_IDLE: begin
                    if (st_sop) begin
                        // MODE 0 waits for an eligible node; MODE 1 swallows a packet
                        // whose fixed node is ineligible instead of stalling the mux.
                        if (MODE == 0) begin
                            st_ready = tgt_ok & can_load;
                        end else begin
                            st_ready = ~tgt_ok | can_load;
                        end
                    end else begin
                        // Mid-packet words with no open packet are flushed.
                        st_ready = 1'b1;
                    end
                    if (st_valid && st_ready && st_sop) begin
                        if (tgt_ok) begin
                            load     = 1'b1;
                            load_idx = tgt_idx;
                            new_pkt  = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                end
                S_FWD: begin
                    // A node going ineligible mid-packet truncates the packet: the
                    // word is taken and discarded rather than stalling upstream.
                    st_ready = elig[sel_q] ? can_load : 1'b1;
                    if (st_valid && st_ready) begin
                        if (elig[sel_q]) begin
                            load = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    st_ready = 1'b1;
                end
                default: begin
                    st_ready = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && st_sop && !st_eop) begin
                    state_d = load ? S_FWD : S_DROP;
                end
            end
            S_FWD: begin
                if (accept) begin
                    if (st_eop) begin
                        state_d = S_IDLE;
                    end else if (drop_inc) begin
                        state_d = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (accept && st_eop) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath next values: node pointers, output register, drop counter
    // ---------------------------------------------------------------
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        if (new_pkt) begin
            sel_d = tgt_idx;
            if (MODE == 0) begin
                rr_ptr_d = wrap_add(tgt_idx, 1);
            end
        end

        out_full_d = out_full_q;
        out_word_d = out_word_q;
        out_tgt_d  = out_tgt_q;
        if (load) begin
            out_full_d = 1'b1;
            out_word_d = {st_channel, st_empty, st_sop, st_eop, st_data};
            for (int i = 0; i < NCOUNT; i++) begin
                out_tgt_d[i] = (load_idx == IDX_W'(i));
            end
        end else if (out_xfer) begin
            out_full_d = 1'b0;
        end

        drop_count_d = drop_count_q;
        if (drop_inc && (drop_count_q != 32'hFFFF_FFFF)) begin
            drop_count_d = drop_count_q + 32'd1;
        end
    end

    assign pnode_valid = out_full_q ? out_tgt_q : '0;
    assign pnode_data  = {NCOUNT{out_word_q}};
    assign drop_count  = drop_count_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pnode_dispatch.sv
// tb_pnode_dispatch: table-driven bench for pnode_dispatch, one instance per dispatch mode.
// Latency: vectors applied on the falling edge, outputs sampled 1 time unit later.
// Backpressure: pnode_ready patterns come from the vector table.
module tb_pnode_dispatch;
    localparam int DATA_W  = 128;
    localparam int CH_W    = 8;
    localparam int NCOUNT  = 8;
    localparam int EMPTY_W = 4;
    localparam int PW      = DATA_W + CH_W + EMPTY_W + 2;

    logic                 clock = 1'b0;
    logic                 sclr;
    logic [DATA_W-1:0]    st_data;
    logic [CH_W-1:0]      st_channel;
    logic [EMPTY_W-1:0]   st_empty;
    logic                 st_sop, st_eop;
    logic                 st_valid0, st_valid1;
    logic                 st_ready0, st_ready1;
    logic [NCOUNT-1:0]    node_enable, node_freeze, pnode_ready;
    logic [NCOUNT*PW-1:0] pdata0, pdata1;
    logic [NCOUNT-1:0]    pvld0, pvld1;
    logic [31:0]          drop0, drop1;
    logic                 busy0, busy1;

    always #5 clock = ~clock;

    pnode_dispatch #(.MODE(0)) u_rr (
        .clock(clock), .sclr(sclr), .st_data(st_data), .st_channel(st_channel),
        .st_empty(st_empty), .st_sop(st_sop), .st_eop(st_eop), .st_valid(st_valid0),
        .st_ready(st_ready0), .node_enable(node_enable), .node_freeze(node_freeze),
        .pnode_data(pdata0), .pnode_valid(pvld0), .pnode_ready(pnode_ready),
        .drop_count(drop0), .busy(busy0)
    );

    pnode_dispatch #(.MODE(1)) u_st (
        .clock(clock), .sclr(sclr), .st_data(st_data), .st_channel(st_channel),
        .st_empty(st_empty), .st_sop(st_sop), .st_eop(st_eop), .st_valid(st_valid1),
        .st_ready(st_ready1), .node_enable(node_enable), .node_freeze(node_freeze),
        .pnode_data(pdata1), .pnode_valid(pvld1), .pnode_ready(pnode_ready),
        .drop_count(drop1), .busy(busy1)
    );

    // One vector = one clock cycle. Inputs apply to that cycle; e_rdy is the
    // combinational answer for those inputs; e_vld/e_tag/e_drop/e_busy are the
    // registered state left by earlier cycles.
    typedef struct packed {
        logic        m;      // 0 = round-robin instance, 1 = static instance
        logic        s;      // sclr
        logic        vld, sop, eop;
        logic [7:0]  ch, tag, en, frz, rdy;
        logic        e_rdy;
        logic [7:0]  e_vld;
        logic [7:0]  e_tag;
        logic [31:0] e_drop;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input int m, input int s, input int vld, input int sop, input int eop,
                       input int ch, input int tag, input int en, input int frz, input int rdy,
                       input int e_rdy, input int e_vld, input int e_tag, input int e_drop,
                       input int e_busy);
        vec_t v;
        v.m = (m != 0); v.s = (s != 0); v.vld = (vld != 0); v.sop = (sop != 0); v.eop = (eop != 0);
        v.ch = 8'(ch); v.tag = 8'(tag); v.en = 8'(en); v.frz = 8'(frz); v.rdy = 8'(rdy);
        v.e_rdy = (e_rdy != 0); v.e_vld = 8'(e_vld); v.e_tag = 8'(e_tag);
        v.e_drop = 32'(e_drop); v.e_busy = (e_busy != 0);
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h, want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_word(input string nm, input int idx, input logic [PW-1:0] act,
                            input logic [PW-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    function automatic int find_tag(input logic [7:0] t);
        for (int j = 0; j < vecs.size(); j++) begin
            if (vecs[j].vld && vecs[j].tag == t) return j;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0]        ew;
        logic [NCOUNT*PW-1:0] pd;
        logic                 found;
        int                   lat;
        int                   j;

        // ---------------- vector table ----------------
        // 1) round-robin, 10 back-to-back 3-word packets -> nodes 0..7,0,1
        for (int k = 0; k < 30; k++) begin
            add(0, 0, 1, (k % 3) == 0, (k % 3) == 2, 'h5A, 'h10 + k, 'hFF, 0, 'hFF,
                1, (k == 0) ? 0 : (1 << (((k - 1) / 3) % 8)), (k == 0) ? 0 : 'h0F + k,
                0, (k % 3) != 0);
        end
        add(0, 0, 0, 0, 0, 'h5A, 0, 'hFF, 0, 'hFF, 1, 'h02, 'h2D, 0, 0);
        // 2) reset, then freeze 0x06 -> nodes 0,3,4,5; all disabled holds; restore wraps to 0
        add(0, 1, 0, 0, 0, 'h5A, 0,     'hFF, 0,    'hFF, 0, 'h00, 0,     0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h40, 'hFF, 'h06, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h41, 'hFF, 'h06, 'hFF, 1, 'h01, 'h40, 0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h42, 'hFF, 'h06, 'hFF, 1, 'h08, 'h41, 0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h43, 'hFF, 'h06, 'hFF, 1, 'h10, 'h42, 0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h44, 'h00, 'h06, 'hFF, 0, 'h20, 'h43, 0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h44, 'h00, 'h06, 'hFF, 0, 'h00, 0,     0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h44, 'h3F, 'h06, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0,    'hFF, 1, 'h01, 'h44, 0, 0);
        // 3) static mode, node 2 disabled: ch9 -> node1, ch2 dropped, ch15 -> node7
        add(1, 0, 1, 1, 1, 'h09, 'h50, 'hFB, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(1, 0, 1, 1, 0, 'h02, 'h51, 'hFB, 0, 'hFF, 1, 'h02, 'h50, 0, 0);
        add(1, 0, 1, 0, 0, 'h02, 'h52, 'hFB, 0, 'hFF, 1, 'h00, 0,     1, 1);
        add(1, 0, 1, 0, 0, 'h02, 'h53, 'hFB, 0, 'hFF, 1, 'h00, 0,     1, 1);
        add(1, 0, 1, 0, 1, 'h02, 'h54, 'hFB, 0, 'hFF, 1, 'h00, 0,     1, 1);
        add(1, 0, 1, 1, 1, 'h0F, 'h55, 'hFB, 0, 'hFF, 1, 'h00, 0,     1, 0);
        add(1, 0, 0, 0, 0, 'h0F, 0,     'hFB, 0, 'hFF, 1, 'h80, 'h55, 1, 0);
        // 4) two singles to nodes 1,2, then 5-word packet to node 3 frozen on word 2
        add(0, 0, 1, 1, 1, 'h5A, 'h60, 'hFF, 0,    'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h61, 'hFF, 0,    'hFF, 1, 'h02, 'h60, 0, 0);
        add(0, 0, 1, 1, 0, 'h5A, 'h62, 'hFF, 0,    'hFF, 1, 'h04, 'h61, 0, 0);
        add(0, 0, 1, 0, 0, 'h5A, 'h63, 'hFF, 0,    'hFF, 1, 'h08, 'h62, 0, 1);
        add(0, 0, 1, 0, 0, 'h5A, 'h64, 'hFF, 'h08, 'hFF, 1, 'h08, 'h63, 0, 1);
        add(0, 0, 1, 0, 0, 'h5A, 'h65, 'hFF, 'h08, 'hFF, 1, 'h00, 0,     1, 1);
        add(0, 0, 1, 0, 1, 'h5A, 'h66, 'hFF, 'h08, 'hFF, 1, 'h00, 0,     1, 1);
        add(0, 0, 1, 1, 1, 'h5A, 'h67, 'hFF, 0,    'hFF, 1, 'h00, 0,     1, 0);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0,    'hFF, 1, 'h10, 'h67, 1, 0);
        // 5) reset, then node 0 stalls 5 cycles mid-packet
        add(0, 1, 0, 0, 0, 'h5A, 0,     'hFF, 0, 'hFF, 0, 'h00, 0,     1, 0);
        add(0, 0, 1, 1, 0, 'h5A, 'h70, 'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 1, 0, 0, 'h5A, 'h71, 'hFF, 0, 'hFF, 1, 'h01, 'h70, 0, 1);
        for (int k = 0; k < 5; k++) begin
            add(0, 0, 1, 0, 0, 'h5A, 'h72, 'hFF, 0, 'hFE, 0, 'h01, 'h71, 0, 1);
        end
        add(0, 0, 1, 0, 0, 'h5A, 'h72, 'hFF, 0, 'hFF, 1, 'h01, 'h71, 0, 1);
        add(0, 0, 1, 0, 0, 'h5A, 'h73, 'hFF, 0, 'hFF, 1, 'h01, 'h72, 0, 1);
        add(0, 0, 1, 0, 0, 'h5A, 'h74, 'hFF, 0, 'hFF, 1, 'h01, 'h73, 0, 1);
        add(0, 0, 1, 0, 1, 'h5A, 'h75, 'hFF, 0, 'hFF, 1, 'h01, 'h74, 0, 1);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0, 'hFF, 1, 'h01, 'h75, 0, 0);
        // 6) sclr in FWD with a held word; next packet to node 0; stray non-sop word flushed
        add(0, 0, 1, 1, 0, 'h5A, 'h80, 'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 1, 0, 0, 'h5A, 'h81, 'hFF, 0, 'hFD, 0, 'h02, 'h80, 0, 1);
        add(0, 1, 1, 0, 0, 'h5A, 'h81, 'hFF, 0, 'hFD, 0, 'h02, 'h80, 0, 1);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 1, 1, 1, 'h5A, 'h82, 'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0, 'hFF, 1, 'h01, 'h82, 0, 0);
        add(0, 0, 1, 0, 1, 'h5A, 'h83, 'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);
        add(0, 0, 0, 0, 0, 'h5A, 0,     'hFF, 0, 'hFF, 1, 'h00, 0,     0, 0);

        // ---------------- reset ----------------
        sclr = 1'b1; st_valid0 = 1'b0; st_valid1 = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
        st_data = '0; st_channel = '0; st_empty = '0;
        node_enable = '1; node_freeze = '0; pnode_ready = '1;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_st_ready", -1, 32'(st_ready0), 0);
        chk("rst_pvld0", -1, 32'(pvld0), 0);
        chk("rst_pvld1", -1, 32'(pvld1), 0);
        chk("rst_pdata0_zero", -1, 32'(pdata0 === '0), 1);
        chk("rst_pdata1_zero", -1, 32'(pdata1 === '0), 1);
        chk("rst_drop", -1, drop0, 0);
        chk("rst_busy", -1, 32'(busy0), 0);
        n_vec++;

        // ---------------- apply table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            sclr        = vecs[i].s;
            st_valid0   = vecs[i].vld & ~vecs[i].m;
            st_valid1   = vecs[i].vld & vecs[i].m;
            st_sop      = vecs[i].sop;
            st_eop      = vecs[i].eop;
            st_channel  = vecs[i].ch;
            st_data     = {16{vecs[i].tag}};
            st_empty    = vecs[i].tag[3:0];
            node_enable = vecs[i].en;
            node_freeze = vecs[i].frz;
            pnode_ready = vecs[i].rdy;
            #1;
            chk("st_ready", i, 32'(vecs[i].m ? st_ready1 : st_ready0), 32'(vecs[i].e_rdy));
            chk("pnode_valid", i, 32'(vecs[i].m ? pvld1 : pvld0), 32'(vecs[i].e_vld));
            chk("drop_count", i, vecs[i].m ? drop1 : drop0, vecs[i].e_drop);
            chk("busy", i, 32'(vecs[i].m ? busy1 : busy0), 32'(vecs[i].e_busy));
            if (vecs[i].e_vld != 8'h00) begin
                j = find_tag(vecs[i].e_tag);
                if (j < 0) begin
                    n_err++;
                    $display("FAIL table_tag vec %0d: got tag %0h, want a sent tag", i, vecs[i].e_tag);
                end else begin
                    ew = {vecs[j].ch, vecs[j].tag[3:0], vecs[j].sop, vecs[j].eop, {16{vecs[j].tag}}};
                    pd = vecs[i].m ? pdata1 : pdata0;
                    chk_word("word_slice0", i, pd[0 +: PW], ew);
                    chk_word("word_slice7", i, pd[(NCOUNT - 1) * PW +: PW], ew);
                end
            end
            n_vec++;
        end

        // ---------------- hand sequence: all nodes disabled, then restored ----------------
        // round-robin pointer is at 1 after the last table packet went to node 0
        @(negedge clock);
        sclr = 1'b0; st_valid0 = 1'b1; st_valid1 = 1'b0; st_sop = 1'b1; st_eop = 1'b1;
        st_channel = 8'h5A; st_data = {16{8'h90}}; st_empty = 4'h0;
        node_enable = '0; node_freeze = '0; pnode_ready = '1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("nodes_off_rdy", c, 32'(st_ready0), 0);
            chk("nodes_off_vld", c, 32'(pvld0), 0);
            n_vec++;
            @(negedge clock);
        end
        node_enable = '1;
        #1;
        chk("restore_rdy", 0, 32'(st_ready0), 1);
        @(negedge clock);
        st_valid0 = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            lat++;
            if (pvld0 != '0) found = 1'b1;
            else @(negedge clock);
        end
        chk("restore_found", 0, 32'(found), 1);
        chk("restore_latency", 0, lat, 1);
        chk("restore_node", 0, 32'(pvld0), 32'h02);
        chk_word("restore_word", 0, pdata0[0 +: PW], {8'h5A, 4'h0, 1'b1, 1'b1, {16{8'h90}}});
        chk("restore_busy", 0, 32'(busy0), 0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
